// File: rtl/fpu_pkg.sv
// Shared types and unit latencies for the FPU issue/writeback sequencer.
// Unit latencies here must stay within the sequencer's MAX_LAT.
package fpu_pkg;

  localparam int NUM_UNIT_MAX = 4;
  localparam int RD_MAX_W     = 8;
  localparam int LAT_W        = 4;

  typedef enum logic [1:0] {
    U_FABS = 2'd0,
    U_FNEG = 2'd1,
    U_FADD = 2'd2,
    U_FMUL = 2'd3
  } unit_e;

  localparam logic [LAT_W-1:0] FPU_LAT [NUM_UNIT_MAX] =
    '{4'd1, 4'd1, 4'd3, 4'd2};

  typedef struct packed {
    logic                valid;
    unit_e               unit;
    logic [RD_MAX_W-1:0] rd;
  } resv_t;

  function automatic logic [LAT_W-1:0] unit_lat(input unit_e u);
    return FPU_LAT[u];
  endfunction

endpackage

// File: rtl/fpu_resv_shift.sv
// Writeback reservation array: shifts toward slot 0 every cycle,
// one indexed write and one indexed valid probe per cycle.
module fpu_resv_shift
  import fpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  resv_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output resv_t            head,
  output logic             any_valid
);

  localparam int RW = $bits(resv_t);

  resv_t [DEPTH-1:0] res_q;
  resv_t [DEPTH-1:0] res_d;

  always_comb begin
    res_d = res_q >> RW;
    for (int k = 0; k < DEPTH; k++) begin
      if (wr_en && wr_idx == IDX_W'(k)) begin
        res_d[k] = wr_data;
      end
    end
  end

  // Indices at or beyond DEPTH read as free.
  always_comb begin
    rd_valid  = 1'b0;
    any_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        rd_valid = res_q[k].valid;
      end
      any_valid = any_valid | res_q[k].valid;
    end
  end

  assign head = res_q[0];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/fpu_issue.sv
// Issue/writeback sequencer for fixed-latency FPU units.
// Define FPU_ISSUE_CHECK_EN to enable the sticky protocol error flag.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int MAX_LAT   = 8,
  parameter int TAG_W     = 6
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_unit,
  input  logic [TAG_W-1:0]       in_rd,
  input  logic [31:0]            in_x,
  input  logic [31:0]            in_z,
  output logic [NUM_UNITS-1:0]   unit_valid,
  output logic [31:0]            unit_x,
  output logic [31:0]            unit_z,
  input  logic [32*NUM_UNITS-1:0] unit_y,
  input  logic [NUM_UNITS-1:0]   unit_out_valid,
  output logic                   wb_valid,
  output logic [TAG_W-1:0]       wb_rd,
  output logic [31:0]            wb_data,
  output logic                   busy,
  output logic                   err
);

  localparam int IDX_W = $clog2(MAX_LAT + 1);

  unit_e            unit_sel;
  logic [LAT_W-1:0] lat;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             slot_busy;
  logic             any_res;
  logic             fire;
  logic             drop;
  logic             wr_en;
  resv_t            wr_res;
  resv_t            head;
  logic [31:0]      y_sel;

  assign unit_sel = unit_e'(in_unit);
  assign lat      = unit_lat(unit_sel);
  assign rd_idx   = IDX_W'(lat);
  assign wr_idx   = IDX_W'(lat - LAT_W'(1));

  assign in_ready = !rst && !slot_busy;
  assign fire     = in_valid && in_ready;
  assign drop     = fire && (int'(in_unit) >= NUM_UNITS);
  assign wr_en    = fire && !drop;

  always_comb begin
    wr_res       = '0;
    wr_res.valid = 1'b1;
    wr_res.unit  = unit_sel;
    wr_res.rd    = RD_MAX_W'(in_rd);
  end

  always_comb begin
    unit_valid = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_valid[i] = wr_en && (in_unit == 2'(i));
    end
  end

  assign unit_x = in_x;
  assign unit_z = in_z;

  fpu_resv_shift #(
    .DEPTH (MAX_LAT),
    .IDX_W (IDX_W)
  ) u_resv (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_res),
    .rd_idx    (rd_idx),
    .rd_valid  (slot_busy),
    .head      (head),
    .any_valid (any_res)
  );

  always_comb begin
    y_sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (head.unit == 2'(i)) begin
        y_sel = unit_y[32*i +: 32];
      end
    end
  end

  // Tag and data hold their last value between writebacks.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= head.valid;
      if (head.valid) begin
        wb_rd   <= head.rd[TAG_W-1:0];
        wb_data <= y_sel;
      end
    end
  end

  assign busy = any_res || wb_valid;

`ifdef FPU_ISSUE_CHECK_EN
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0]     mask_cnt;
  logic [NUM_UNITS-1:0] due;
  logic                 viol;
  logic                 err_q;

  always_comb begin
    due = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      due[i] = head.valid && (head.unit == 2'(i));
    end
    viol = drop
        || (|(unit_out_valid & ~due))
        || (head.valid && !(|(unit_out_valid & due)));
  end

  // Masking window lets results from before reset drain harmlessly.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mask_cnt <= CNT_W'(MAX_LAT);
      err_q    <= 1'b0;
    end else begin
      if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - CNT_W'(1);
      end
      if (mask_cnt == '0 && viol) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{head.rd, unit_out_valid, drop};

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Issue and writeback sequencer for the fixed-latency FPU units such as fabs, fneg, fadd and fmul. It accepts decoded FP operations over a valid/ready handshake and drives each unit's `stage1_valid` and operands. It reserves the single writeback slot each result will use and collects the unit's `y`/`out_valid` at the predicted cycle. It then presents one result per cycle, tagged with its destination register, to the FP register file.

## Interface
Parameters:
- `NUM_UNITS`, 4: number of attached FPU units (1..4).
- `MAX_LAT`, 8: maximum unit latency in cycles; this is the reservation depth.
- `TAG_W`, 6: destination register tag width.

Ports:
- `sys_clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: an operation is offered.
- `in_ready` output 1: the operation is accepted this cycle if `in_valid` is also high.
- `in_unit` input 2: target unit index.
- `in_rd` input TAG_W: destination tag.
- `in_x`, `in_z` input 32 each: operands.
- `unit_valid` output NUM_UNITS: one-hot `stage1_valid` to the units.
- `unit_x`, `unit_z` output 32 each: operands broadcast to all units.
- `unit_y` input 32*NUM_UNITS: unit results; unit i occupies bits [32i+31:32i].
- `unit_out_valid` input NUM_UNITS: unit result-valid signals.
- `wb_valid` output 1: writeback strobe.
- `wb_rd` output TAG_W: writeback tag.
- `wb_data` output 32: writeback data.
- `busy` output 1: any reservation is pending or `wb_valid` is high.
- `err` output 1: sticky protocol error flag (see Configuration).

## Operation
- Each unit's latency L(u) comes from the package constant `FPU_LAT[u]`, with 1 <= L <= MAX_LAT. A unit that sees `stage1_valid` in cycle t asserts `out_valid` in cycle t+L.
- Reservation array `res[0..MAX_LAT-1]`: each entry holds {valid, unit, rd}. `res[k]` valid means a result is due k cycles from now.
- Every edge shifts the array: `res[k] <= res[k+1]`; the top entry is filled with invalid.
- Issue occurs when `in_valid && in_ready`, at which point:
  - `unit_valid[in_unit]` is high in the same cycle (combinational);
  - `unit_x`/`unit_z` equal `in_x`/`in_z`;
  - on the edge, `res[L-1] <= {1, in_unit, in_rd}`.
- `in_ready` = !rst && !res[L(in_unit)].valid. For L = MAX_LAT the slot index is out of range and treated as free. This is a combinational function of `in_unit`.
- If `in_unit >= NUM_UNITS`, the operation is accepted and dropped: no `unit_valid`, no reservation.
- Collection: when `res[0].valid`, the next edge registers `wb_valid` = 1, `wb_rd` = `res[0].rd` and `wb_data` = `unit_y[res[0].unit]`. Otherwise `wb_valid` = 0 and `wb_rd`/`wb_data` hold their values.
- At most one issue and at most one writeback occur per cycle. An issue and a writeback in the same cycle are independent.
- Reset mid-operation clears all reservations. Results of in-flight operations are discarded and never written back. Units are not reset by this block.

## Timing
- Issue-to-writeback latency is L+1 cycles: issue in cycle t, `wb_valid` high in cycle t+L+1.
- Throughput is one operation per cycle when due cycles do not collide.
- Slot conflict: a new operation is stalled (`in_ready` = 0) exactly when its due cycle is already reserved. It is accepted the first cycle its slot is free. Stalls are never caused by the unit itself.
- Reset values: `wb_valid` 0, `wb_rd` 0, `wb_data` 0, `busy` 0, `err` 0, all `res` invalid. `in_ready` and `unit_valid` are 0 while `rst` is high.

## Configuration
- Macro `FPU_ISSUE_CHECK_EN`, defined: each cycle, `err` is set (sticky until reset) if any of these hold:
  - `res[0].valid` and `unit_out_valid[res[0].unit]` is 0;
  - any `unit_out_valid[i]` is high for a unit not due this cycle;
  - an operation is dropped because of an invalid `in_unit`.
- The check is masked for MAX_LAT cycles after reset deassertion, using a down-counter, so that stale unit results are ignored.
- Macro not defined: `err` is tied to 0, and no counter or comparison logic is generated.

## Structure
- Package `fpu_pkg` holds:
  - the `FPU_LAT` constant array (unit 0 fabs = 1, unit 1 fneg = 1, unit 2 fadd = 3, unit 3 fmul = 2);
  - the unit index enum;
  - the `resv_t` struct {valid, unit, rd}.
- One sub-module, `fpu_resv_shift`: the reservation shift array with a write port at a given index and a read of `res[0]` and of an arbitrary index.

## Test plan
- Issue fabs (unit 0), rd = 5, x = 0xBF800000 in cycle 0, with a unit model returning |x| after 1 cycle -> `wb_valid` in cycle 2 with `wb_rd` = 5 and `wb_data` = 0x3F800000.
- Issue fadd (L = 3) in cycle 0, then offer fabs (L = 1) in cycle 2 -> `in_ready` = 0 in cycle 2, fabs accepted in cycle 3. Writebacks: fadd in cycle 4, fabs in cycle 5.
- Issue fabs every cycle for 10 cycles with rd = 0..9 -> `in_ready` stays high and `wb_rd` = 0..9 appears in consecutive cycles 2..11.
- Issue fmul and fadd, then assert `rst` in cycle 2 -> no `wb_valid` ever appears for them. `busy` = 0 and outputs return to reset values immediately.
- With `FPU_ISSUE_CHECK_EN` defined, inject `unit_out_valid[3]` with no reservation after the mask expires -> `err` = 1 the next cycle and stays 1 until reset. Injecting the same during the first MAX_LAT cycles after reset leaves `err` = 0.
- Without the macro, the same injection leaves `err` = 0.
